health_ctl: RTL and testbench

Game-side owner of the player's hit points. It tracks remaining lives, applies hits and heals, and times a post-hit invulnerability window with a blinking heart. It drives the 3-bit `health_en` heart mask and a `game_over` flag. It sits between the collision/game logic and the heart-drawing stage of the VGA pipeline, which draws heart `i` when `health_en[i]` is 1.

---
 rtl/game_pkg.sv | 24 ++
 rtl/health_ctl.sv | 141 ++++++++++++++
 tb/tb_health_ctl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game-side types and helpers: health FSM states and the lives-to-heart mask.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIVE  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } health_state_t;

  localparam int MAX_HEALTH_C = 3;

  function automatic logic [2:0] health_mask(input logic [1:0] lives);
    logic [2:0] mask;
    case (lives)
      2'd3:    mask = 3'b111;
      2'd2:    mask = 3'b011;
      2'd1:    mask = 3'b001;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/health_ctl.sv
// Player hit-point owner: lives, hits/heals, post-hit invulnerability with a blinking
// heart, and the registered heart mask / game-over flag for the heart-drawing stage.
module health_ctl
  import game_pkg::*;
#(
  parameter int MAX_HEALTH    = MAX_HEALTH_C,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_LOG2    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_game,
  input  logic       vsync,
  input  logic       hit,
  input  logic       heal,
  output logic [2:0] health_en,
  output logic       invuln,
  output logic       game_over
);

  localparam int INV_W = $clog2(INVULN_FRAMES + 1);
  localparam int FC_W  = BLINK_LOG2 + 1;
  localparam logic [1:0]       MAX_L    = 2'(MAX_HEALTH);
  localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_FRAMES);

  health_state_t    state_q, state_d;
  logic [1:0]       lives_q, lives_d;
  logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic             vsync_q;
  logic [2:0]       health_en_q, health_en_d;
  logic             invuln_q, invuln_d;
  logic             game_over_q, game_over_d;
  logic             frameTick;
  logic [2:0]       blinkBit;

  assign frameTick = vsync & ~vsync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lives_q     <= MAX_L;
      inv_cnt_q   <= '0;
      frame_cnt_q <= '0;
      vsync_q     <= 1'b0;
      health_en_q <= health_mask(MAX_L);
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      inv_cnt_q   <= inv_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      vsync_q     <= vsync;
      health_en_q <= health_en_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  // Dropping start_game aborts any running game and outranks hit/heal in the same cycle.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    inv_cnt_d   = inv_cnt_q;
    frame_cnt_d = frameTick ? frame_cnt_q + FC_W'(1) : frame_cnt_q;
    case (state_q)
      IDLE: begin
        lives_d   = MAX_L;
        inv_cnt_d = '0;
        if (start_game) state_d = ALIVE;
      end
      ALIVE: begin
        if (!start_game) begin
          state_d = IDLE;
          lives_d = MAX_L;
        end else if (hit) begin
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) begin
            state_d = DEAD;
          end else begin
            state_d     = INVULN;
            inv_cnt_d   = INV_LOAD;
            frame_cnt_d = '0;
          end
        end else if (heal && lives_q < MAX_L) begin
          lives_d = lives_q + 2'd1;
        end
      end
      INVULN: begin
        if (!start_game) begin
          state_d = IDLE;
          lives_d = MAX_L;
        end else begin
          if (heal && lives_q < MAX_L) lives_d = lives_q + 2'd1;
          if (frameTick) begin
            if (inv_cnt_q <= INV_W'(1)) begin
              state_d   = ALIVE;
              inv_cnt_d = '0;
            end else begin
              inv_cnt_d = inv_cnt_q - INV_W'(1);
            end
          end
        end
      end
      DEAD: begin
        if (!start_game) begin
          state_d = IDLE;
          lives_d = MAX_L;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The just-lost heart sits one position above the lit ones; at full health it falls off the mask.
  always_comb begin
    health_en_d = health_mask(MAX_L);
    invuln_d    = 1'b0;
    game_over_d = 1'b0;
    blinkBit    = (lives_q == 2'd3) ? 3'b000 : (3'b001 << lives_q);
    case (state_q)
      IDLE:   health_en_d = health_mask(MAX_L);
      ALIVE:  health_en_d = health_mask(lives_q);
      INVULN: begin
        invuln_d    = 1'b1;
        health_en_d = health_mask(lives_q) | (frame_cnt_q[BLINK_LOG2] ? 3'b000 : blinkBit);
      end
      DEAD: begin
        health_en_d = 3'b000;
        game_over_d = 1'b1;
      end
      default: health_en_d = health_mask(MAX_L);
    endcase
  end

  assign health_en = health_en_q;
  assign invuln    = invuln_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_health_ctl.sv
// Self-checking bench for health_ctl: directed game scenarios followed by random
// stimulus, every cycle compared against a lives/ticks reference model.
module tb_health_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       startGame, vsync, hit, heal;
  logic [2:0] healthEn;
  logic       invuln, gameOver;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: phase 0 idle, 1 playing, 2 invulnerable, 3 dead.
  int mPhase, mLives, mTicksLeft, mTicksSince;
  bit mPrevVsync;
  int eHealth, eInv, eOver;

  always #5 clk = ~clk;

  health_ctl #(.MAX_HEALTH(3), .INVULN_FRAMES(120), .BLINK_LOG2(3)) dut (
    .clk(clk), .rst(rst), .start_game(startGame), .vsync(vsync),
    .hit(hit), .heal(heal), .health_en(healthEn), .invuln(invuln), .game_over(gameOver)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPhase = 0; mLives = 3; mTicksLeft = 0; mTicksSince = 0; mPrevVsync = 0;
    eHealth = 7; eInv = 0; eOver = 0;
  endtask

  task automatic modelOutputs();
    eInv = 0; eOver = 0;
    case (mPhase)
      0: eHealth = 7;
      1: eHealth = (1 << mLives) - 1;
      2: begin
        eInv = 1;
        eHealth = (1 << mLives) - 1;
        if (((mTicksSince / 8) % 2) == 0 && mLives < 3) eHealth = eHealth | (1 << mLives);
      end
      default: begin eHealth = 0; eOver = 1; end
    endcase
  endtask

  task automatic modelEdge();
    bit tick;
    tick = vsync && !mPrevVsync;
    mPrevVsync = vsync;
    modelOutputs();
    if (mPhase != 0 && !startGame) begin
      mPhase = 0; mLives = 3;
    end else begin
      case (mPhase)
        0: if (startGame) mPhase = 1;
        1: begin
          if (hit) begin
            mLives = mLives - 1;
            if (mLives == 0) mPhase = 3;
            else begin mPhase = 2; mTicksLeft = 120; mTicksSince = 0; end
          end else if (heal && mLives < 3) mLives++;
        end
        2: begin
          if (heal && mLives < 3) mLives++;
          if (tick) begin
            mTicksLeft--; mTicksSince++;
            if (mTicksLeft == 0) mPhase = 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input bit s, input bit v, input bit h, input bit hl);
    startGame = s; vsync = v; hit = h; heal = hl;
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput("health_en", int'(healthEn), eHealth);
    checkOutput("invuln", int'(invuln), eInv);
    checkOutput("game_over", int'(gameOver), eOver);
  endtask

  task automatic runFrames(input int n, input bit hitFirst);
    for (int f = 0; f < n; f++) begin
      applyStimulus(1, 1, hitFirst, 0);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
    end
  endtask

  task automatic pulse(input bit h, input bit hl);
    applyStimulus(1, 0, h, hl);
    applyStimulus(1, 0, 0, 0);
  endtask

  initial begin
    startGame = 0; vsync = 0; hit = 0; heal = 0;
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_health_en", int'(healthEn), 7);
    checkOutput("reset_invuln", int'(invuln), 0);
    checkOutput("reset_game_over", int'(gameOver), 0);
    rst = 1'b0;

    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("start_hearts", int'(healthEn), 7);

    // First hit: blink on, then off after 8 ticks, then invulnerability expires.
    pulse(1, 0);
    checkOutput("hit_blink_on", int'(healthEn), 7);
    checkOutput("hit_invuln", int'(invuln), 1);
    runFrames(8, 0);
    checkOutput("blink_off", int'(healthEn), 3);
    runFrames(50, 1);
    checkOutput("hit_ignored_invuln", int'(invuln), 1);
    runFrames(62, 0);
    checkOutput("invuln_expired", int'(invuln), 0);
    checkOutput("after_invuln_hearts", int'(healthEn), 3);

    // Abort and restart, then hit+heal together and heals during invulnerability.
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("restart_hearts", int'(healthEn), 7);
    pulse(1, 1);
    checkOutput("hit_beats_heal_inv", int'(invuln), 1);
    pulse(0, 1);
    runFrames(10, 0);
    checkOutput("healed_steady", int'(healthEn), 7);
    pulse(0, 1);
    runFrames(110, 0);
    checkOutput("heal_saturated", int'(healthEn), 7);

    // Three spaced hits end the game.
    pulse(1, 0);
    runFrames(121, 0);
    pulse(1, 0);
    runFrames(121, 0);
    pulse(1, 0);
    checkOutput("dead_hearts", int'(healthEn), 0);
    checkOutput("dead_flag", int'(gameOver), 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("new_game_hearts", int'(healthEn), 7);
    checkOutput("new_game_flag", int'(gameOver), 0);

    // Async reset in the middle of the last-life invulnerability window.
    pulse(1, 0);
    runFrames(121, 0);
    pulse(1, 0);
    runFrames(3, 0);
    checkOutput("last_life_invuln", int'(invuln), 1);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_health_en", int'(healthEn), 7);
    checkOutput("async_rst_invuln", int'(invuln), 0);
    checkOutput("async_rst_game_over", int'(gameOver), 0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0);

    // Random play.
    begin
      bit v = 0;
      for (int c = 0; c < 6000; c++) begin
        if ($urandom_range(2) == 0) v = ~v;
        applyStimulus($urandom_range(199) != 0, v,
                      $urandom_range(29) == 0, $urandom_range(29) == 0);
      end
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
